// File: rtl/chacha_rounds.sv
// Iterative ChaCha permutation engine, QR_PER_CYCLE quarter-rounds per clock, run-time round count.
// Define CHACHA_FEEDFORWARD_EN to add the saved input state to the result (ChaCha block function output).
module chacha_rounds #(
  parameter int QR_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [4:0]   rounds,
  input  logic [511:0] state_in,
  output logic         ready,
  output logic         valid,
  output logic [511:0] state_out
);

  localparam int         STEPS     = 4 / QR_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  generate
    if (QR_PER_CYCLE != 1 && QR_PER_CYCLE != 2 && QR_PER_CYCLE != 4) begin : g_bad_qr_per_cycle
      $error("chacha_rounds: QR_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUNDS, FINAL, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_work [16];
`ifdef CHACHA_FEEDFORWARD_EN
  logic [31:0] r_saved [16];
`endif
  logic [4:0]  r_rounds;
  logic [4:0]  r_round;
  logic [1:0]  r_step;

  logic [31:0]  w_in   [16];
  logic [31:0]  w_next [16];
  logic [127:0] w_qr   [QR_PER_CYCLE];
  logic [511:0] w_final;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] quarterRound(input logic [31:0] a_in, input logic [31:0] b_in,
                                                input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Row r of QR q sits in column q, shifted by r on diagonal rounds.
  function automatic logic [3:0] wordIdx(input logic [1:0] step, input int lane,
                                         input logic diag, input logic [1:0] row);
    logic [1:0] q;
    logic [1:0] col;
    q   = 2'(int'(step) * QR_PER_CYCLE + lane);
    col = q + (diag ? row : 2'd0);
    return {row, col};
  endfunction

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_in[i] = state_in[511 - 32*i -: 32];
    end
  end

  always_comb begin
    w_next = r_work;
    for (int p = 0; p < QR_PER_CYCLE; p++) begin
      w_qr[p] = quarterRound(r_work[wordIdx(r_step, p, r_round[0], 2'd0)],
                             r_work[wordIdx(r_step, p, r_round[0], 2'd1)],
                             r_work[wordIdx(r_step, p, r_round[0], 2'd2)],
                             r_work[wordIdx(r_step, p, r_round[0], 2'd3)]);
      w_next[wordIdx(r_step, p, r_round[0], 2'd0)] = w_qr[p][127:96];
      w_next[wordIdx(r_step, p, r_round[0], 2'd1)] = w_qr[p][95:64];
      w_next[wordIdx(r_step, p, r_round[0], 2'd2)] = w_qr[p][63:32];
      w_next[wordIdx(r_step, p, r_round[0], 2'd3)] = w_qr[p][31:0];
    end
  end

  always_comb begin
    w_final = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef CHACHA_FEEDFORWARD_EN
      w_final[511 - 32*i -: 32] = r_work[i] + r_saved[i];
`else
      w_final[511 - 32*i -: 32] = r_work[i];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      ready     <= 1'b1;
      valid     <= 1'b0;
      state_out <= '0;
      r_rounds  <= '0;
      r_round   <= '0;
      r_step    <= '0;
      for (int i = 0; i < 16; i++) begin
        r_work[i] <= '0;
`ifdef CHACHA_FEEDFORWARD_EN
        r_saved[i] <= '0;
`endif
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (init) begin
            r_work   <= w_in;
`ifdef CHACHA_FEEDFORWARD_EN
            r_saved  <= w_in;
`endif
            r_rounds <= rounds;
            r_round  <= '0;
            r_step   <= '0;
            ready    <= 1'b0;
            valid    <= 1'b0;
            r_state  <= (rounds == 5'd0) ? FINAL : ROUNDS;
          end
        end
        ROUNDS: begin
          r_work <= w_next;
          if (r_step == LAST_STEP) begin
            r_step  <= '0;
            r_round <= r_round + 5'd1;
            if (r_round == r_rounds - 5'd1) begin
              r_state <= FINAL;
            end
          end else begin
            r_step <= r_step + 2'd1;
          end
        end
        FINAL: begin
          state_out <= w_final;
          valid     <= 1'b1;
          ready     <= 1'b1;
          r_state   <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_rounds.sv
// Scoreboard bench for chacha_rounds: directed vectors, odd/zero/max round counts, busy init,
// async reset mid-run and back-to-back blocks; follows CHACHA_FEEDFORWARD_EN like the design.
module tb_chacha_rounds;

  localparam int QPC   = 4;
  localparam int STEPS = 4 / QPC;
  localparam int LIMIT = 31 * STEPS + 10;
`ifdef CHACHA_FEEDFORWARD_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         init;
  logic [4:0]   rounds;
  logic [511:0] state_in;
  logic         ready;
  logic         valid;
  logic [511:0] state_out;

  typedef struct {
    string        tag;
    logic [511:0] exp;
    int           lat;
  } sbEntry_t;

  sbEntry_t sb[$];
  int nCompared   = 0;
  int nMismatched = 0;

  chacha_rounds #(.QR_PER_CYCLE(QPC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init      (init),
    .rounds    (rounds),
    .state_in  (state_in),
    .ready     (ready),
    .valid     (valid),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wordOf(input logic [511:0] s, input int i);
    return s[511 - 32*i -: 32];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook ChaCha: explicit column/diagonal index tables, one full round at a time.
  function automatic logic [511:0] chachaModel(input logic [511:0] s, input int n);
    int          qt [8][4];
    logic [31:0] x  [16];
    logic [31:0] a, b, c, d;
    logic [511:0] r;
    qt = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
           '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    for (int i = 0; i < 16; i++) x[i] = wordOf(s, i);
    for (int rd = 0; rd < n; rd++) begin
      for (int q = 0; q < 4; q++) begin
        a = x[qt[(rd % 2) * 4 + q][0]];
        b = x[qt[(rd % 2) * 4 + q][1]];
        c = x[qt[(rd % 2) * 4 + q][2]];
        d = x[qt[(rd % 2) * 4 + q][3]];
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        x[qt[(rd % 2) * 4 + q][0]] = a;
        x[qt[(rd % 2) * 4 + q][1]] = b;
        x[qt[(rd % 2) * 4 + q][2]] = c;
        x[qt[(rd % 2) * 4 + q][3]] = d;
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[511 - 32*i -: 32] = FF ? (x[i] + wordOf(s, i)) : x[i];
    end
    return r;
  endfunction

  function automatic logic [511:0] randState();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one accepted init at a negedge; returns at the negedge just after the accepting edge.
  task automatic applyStimulus(input logic [511:0] s, input logic [4:0] n, input string tag);
    @(negedge clk);
    state_in = s;
    rounds   = n;
    init     = 1'b1;
    sb.push_back('{tag, chachaModel(s, int'(n)), int'(n) * STEPS + 1});
    @(negedge clk);
    init = 1'b0;
  endtask

  // Counts edges since accept until valid, then pops and compares the oldest expectation.
  task automatic checkOutput(input int startCnt);
    sbEntry_t e;
    int cnt;
    cnt = startCnt;
    while (valid !== 1'b1 && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    e = sb.pop_front();
    chk({e.tag, " latency"}, 512'(cnt), 512'(e.lat));
    chk({e.tag, " ready"}, 512'(ready), 512'(1'b1));
    chk({e.tag, " data"}, state_out, e.exp);
  endtask

  logic [511:0] rfcState;
  logic [511:0] qrState;
  logic [511:0] zeroRoundState;
  logic [511:0] busyA;
  logic [511:0] busyB;
  logic [511:0] b2bA;
  logic [511:0] b2bB;
  int           b2bCnt;

  initial begin
    rfcState = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    qrState = '0;
    qrState[511 - 32*0  -: 32] = 32'h11111111;
    qrState[511 - 32*4  -: 32] = 32'h01020304;
    qrState[511 - 32*8  -: 32] = 32'h9b8d6f43;
    qrState[511 - 32*12 -: 32] = 32'h01234567;
    zeroRoundState = randState();
    zeroRoundState[511 -: 32] = 32'hffffffff;

    reset_n  = 1'b0;
    init     = 1'b0;
    rounds   = '0;
    state_in = '0;
    @(negedge clk);
    chk("reset ready", 512'(ready), 512'(1'b1));
    chk("reset valid", 512'(valid), 512'(1'b0));
    chk("reset state_out", state_out, '0);
    reset_n = 1'b1;

    // Single column round on the quarter-round test vector.
    applyStimulus(qrState, 5'd1, "qr vector");
    checkOutput(0);
    chk("qr word0", 512'(wordOf(state_out, 0)), 512'(32'hea2a92f4 + (FF ? 32'h11111111 : 32'h0)));
    chk("qr word4", 512'(wordOf(state_out, 4)), 512'(32'hcb1cf8ce + (FF ? 32'h01020304 : 32'h0)));
    chk("qr word8", 512'(wordOf(state_out, 8)), 512'(32'h4581472e + (FF ? 32'h9b8d6f43 : 32'h0)));
    chk("qr word12", 512'(wordOf(state_out, 12)), 512'(32'h5881c4bb + (FF ? 32'h01234567 : 32'h0)));

    applyStimulus(rfcState, 5'd20, "rfc 20 rounds");
    checkOutput(0);
    chk("rfc word0", 512'(wordOf(state_out, 0)), 512'(FF ? 32'he4e7f110 : 32'h837778ab));
    chk("rfc word1", 512'(wordOf(state_out, 1)), 512'(FF ? 32'h15593bd1 : 32'he238d763));
    chk("rfc word15", 512'(wordOf(state_out, 15)), 512'(32'h4e3c50a2));

    applyStimulus(zeroRoundState, 5'd0, "zero rounds");
    checkOutput(0);
    chk("zero rounds word0", 512'(wordOf(state_out, 0)), 512'(FF ? 32'hfffffffe : 32'hffffffff));

    applyStimulus(randState(), 5'd3, "odd rounds");
    checkOutput(0);
    applyStimulus(randState(), 5'd31, "max rounds");
    checkOutput(0);

    // A second init while busy must be ignored entirely.
    busyA = randState();
    busyB = randState();
    applyStimulus(busyA, 5'd20, "busy first");
    repeat (3) @(negedge clk);
    state_in = busyB;
    rounds   = 5'd2;
    init     = 1'b1;
    chk("busy ready low", 512'(ready), 512'(1'b0));
    @(negedge clk);
    init = 1'b0;
    chk("busy ready still low", 512'(ready), 512'(1'b0));
    checkOutput(4);

    // Asynchronous reset between edges discards the run in progress.
    applyStimulus(rfcState, 5'd20, "aborted");
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset ready", 512'(ready), 512'(1'b1));
    chk("midreset valid", 512'(valid), 512'(1'b0));
    chk("midreset state_out", state_out, '0);
    void'(sb.pop_front());
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(rfcState, 5'd20, "rfc after reset");
    checkOutput(0);

    // Back-to-back: init held high, second block taken the cycle valid rises.
    b2bA = randState();
    b2bB = randState();
    @(negedge clk);
    state_in = b2bA;
    rounds   = 5'd8;
    init     = 1'b1;
    sb.push_back('{"b2b first", chachaModel(b2bA, 8), 8 * STEPS + 1});
    @(negedge clk);
    checkOutput(0);
    state_in = b2bB;
    rounds   = 5'd12;
    sb.push_back('{"b2b second", chachaModel(b2bB, 12), 12 * STEPS + 1});
    @(negedge clk);
    init = 1'b0;
    chk("b2b valid drops", 512'(valid), 512'(1'b0));
    chk("b2b ready drops", 512'(ready), 512'(1'b0));
    b2bCnt = 0;
    checkOutput(b2bCnt);

    repeat (2) @(negedge clk);
    chk("done holds valid", 512'(valid), 512'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
